// File: rtl/ram_burst_reader_if.sv
// Bus bundle for ram_burst_reader: control, RAM read port, output stream and debug state.
// Stream handshake: a word moves on a rising clk edge where valid & ready are both 1;
// the reader holds data/last steady while valid=1 and ready=0, and never drops valid without a transfer.
interface ram_burst_reader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [ADDR_WIDTH:0]   len;
    logic                  busy;
    logic                  done;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  ram_rd_en;
    logic [DATA_WIDTH-1:0] ram_rd_data;
    logic                  ram_rd_ack;
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;
    logic                  last;
    logic [31:0]           perf_stall;
    logic [1:0]            dbg_state;

    modport master (
        input  start, base_addr, len, ram_rd_data, ram_rd_ack, ready,
        output busy, done, ram_addr, ram_rd_en, data, valid, last, perf_stall, dbg_state
    );

    modport slave (
        output start, base_addr, len, ram_rd_data, ram_rd_ack, ready,
        input  busy, done, ram_addr, ram_rd_en, data, valid, last, perf_stall, dbg_state
    );
endinterface

// File: rtl/ram_burst_reader.sv
// Burst read engine: streams len words from base out of a 1-cycle-latency RAM port through a
// credit-limited skid FIFO. Define RAM_BURST_READER_PERF_EN to build the backpressure stall counter.
module ram_burst_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int RAM_DEPTH  = 512,
    parameter int FIFO_DEPTH = 4
) (
    input logic                clk,
    input logic                rst_n,
    ram_burst_reader_if.master bus
);
    localparam int ADDR_WIDTH = $clog2(RAM_DEPTH);
    localparam int LEN_WIDTH  = ADDR_WIDTH + 1;
    localparam int PTR_WIDTH  = $clog2(FIFO_DEPTH);
    localparam int CNT_WIDTH  = PTR_WIDTH + 1;
    localparam int OCC_WIDTH  = CNT_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0]  DEPTH_CNT = CNT_WIDTH'(FIFO_DEPTH);
    localparam logic [OCC_WIDTH-1:0]  DEPTH_OCC = OCC_WIDTH'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(RAM_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  issued;
    logic [LEN_WIDTH-1:0]  accepted;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  rd_en_q;
    logic                  done_q;
    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr;
    logic [PTR_WIDTH-1:0]  rd_ptr;
    logic [CNT_WIDTH-1:0]  count;

    logic                  valid;
    logic                  push;
    logic                  pop;
    logic                  last_accept;
    logic [CNT_WIDTH-1:0]  count_next;
    logic [LEN_WIDTH-1:0]  issued_next;
    logic [OCC_WIDTH-1:0]  occ_next;
    logic [ADDR_WIDTH-1:0] addr_next;

    // Read enable is registered, so credit is judged on next-cycle occupancy:
    // FIFO contents after this edge plus the read currently on the RAM port.
    always_comb begin
        valid       = (count != '0);
        pop         = valid & bus.ready;
        push        = bus.ram_rd_ack & (state != IDLE);
        last_accept = pop & (accepted == len_q - LEN_WIDTH'(1));
        count_next  = count + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
        issued_next = issued + LEN_WIDTH'(rd_en_q);
        occ_next    = {1'b0, count_next} + OCC_WIDTH'(rd_en_q);
        addr_next   = (addr_q == ADDR_LAST) ? '0 : addr_q + ADDR_WIDTH'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            len_q    <= '0;
            issued   <= '0;
            accepted <= '0;
            addr_q   <= '0;
            rd_en_q  <= 1'b0;
            done_q   <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            done_q <= 1'b0;
            count  <= count_next;
            if (push) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            if (pop) begin
                rd_ptr   <= rd_ptr + PTR_WIDTH'(1);
                accepted <= accepted + LEN_WIDTH'(1);
            end
            case (state)
                IDLE: begin
                    rd_en_q <= 1'b0;
                    if (bus.start) begin
                        if (bus.len != '0) begin
                            state    <= ISSUE;
                            len_q    <= bus.len;
                            issued   <= '0;
                            accepted <= '0;
                            addr_q   <= bus.base_addr;
                            rd_en_q  <= 1'b1;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    issued  <= issued_next;
                    if (rd_en_q) addr_q <= addr_next;
                    rd_en_q <= (issued_next < len_q) && (occ_next < DEPTH_OCC);
                    if (last_accept) begin
                        state   <= IDLE;
                        rd_en_q <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (issued == len_q) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    rd_en_q <= 1'b0;
                    if (last_accept) begin
                        state  <= IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    rd_en_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= bus.ram_rd_data;
    end

    // Credit accounting must make this impossible.
    assert property (@(posedge clk) disable iff (!rst_n) !(push && (count == DEPTH_CNT)));

`ifdef RAM_BURST_READER_PERF_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if ((state == IDLE) && bus.start) begin
            stall_cnt <= '0;
        end else if (valid && !bus.ready && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign bus.perf_stall = stall_cnt;
`else
    assign bus.perf_stall = '0;
`endif

    // Data is gated so the stream bus reads zero whenever nothing is offered.
    assign bus.data      = valid ? fifo_mem[rd_ptr] : '0;
    assign bus.valid     = valid;
    assign bus.last      = valid & (accepted == len_q - LEN_WIDTH'(1));
    assign bus.busy      = (state != IDLE);
    assign bus.done      = done_q;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_rd_en = rd_en_q;
    assign bus.dbg_state = state;
endmodule

// File: tb/tb_ram_burst_reader.sv
// Self-checking bench for ram_burst_reader: behavioural RAM, randomized bursts and backpressure,
// expected words built from base/len with modular address arithmetic.
module tb_ram_burst_reader;
    localparam int DATA_WIDTH = 32;
    localparam int RAM_DEPTH  = 512;
    localparam int FIFO_DEPTH = 4;
    localparam int ADDR_WIDTH = 9;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram_burst_reader_if #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

    ram_burst_reader #(
        .DATA_WIDTH(DATA_WIDTH),
        .RAM_DEPTH (RAM_DEPTH),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Behavioural RAM port: registered read data, ack is read enable delayed one cycle.
    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ram_rd_ack  <= 1'b0;
            bus.ram_rd_data <= '0;
        end else begin
            bus.ram_rd_ack <= bus.ram_rd_en;
            if (bus.ram_rd_en) bus.ram_rd_data <= mem[bus.ram_addr];
        end
    end

    int vectors = 0;
    int miscompares = 0;

    // Observations collected by run_burst.
    logic [DATA_WIDTH-1:0] got_data[$];
    bit                    got_last[$];
    logic [ADDR_WIDTH-1:0] got_addr[$];
    int done_cnt, first_valid_cyc, last_acc_cyc, done_cyc;
    int stall_viol, max_occ, reads_in_hold;
    bit timed_out;

    // Drives one burst and records what the stream and RAM port did.
    // mode 0: ready=1; mode 1: random ready; mode 2: ready=0 for cycles 1..hold.
    task automatic run_burst(input int base, input int len, input int mode,
                             input int hold, input int restart_cyc);
        int cyc, occ, limit, post;
        logic [DATA_WIDTH-1:0] prev_data;
        bit prev_stall;
        got_data.delete();
        got_last.delete();
        got_addr.delete();
        done_cnt = 0; first_valid_cyc = -1; last_acc_cyc = -1; done_cyc = -1;
        stall_viol = 0; max_occ = 0; reads_in_hold = 0; timed_out = 0;
        occ = 0; prev_stall = 0; prev_data = '0; post = -1;
        limit = 100 + 4 * len + hold;
        cyc = 0;
        while (post != 0 && cyc < limit) begin
            @(negedge clk);
            if (cyc == 0) begin
                bus.start = 1'b1;
                bus.base_addr = ADDR_WIDTH'(base);
                bus.len = (ADDR_WIDTH + 1)'(len);
            end else if (cyc == restart_cyc) begin
                bus.start = 1'b1;
                bus.base_addr = ADDR_WIDTH'(base + 100);
                bus.len = 10'd3;
            end else begin
                bus.start = 1'b0;
            end
            case (mode)
                0:       bus.ready = 1'b1;
                1:       bus.ready = 1'($urandom_range(0, 1));
                default: bus.ready = (cyc >= 1 && cyc <= hold) ? 1'b0 : 1'b1;
            endcase
            if (prev_stall && (!bus.valid || bus.data !== prev_data)) stall_viol++;
            if (bus.ram_rd_en) begin
                got_addr.push_back(bus.ram_addr);
                if (cyc <= hold) reads_in_hold++;
            end
            if (bus.valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
                if (post < 0) post = 3;
            end
            if (bus.valid && bus.ready) begin
                got_data.push_back(bus.data);
                got_last.push_back(bus.last);
                last_acc_cyc = cyc;
            end
            occ = occ + int'(bus.ram_rd_ack) - int'(bus.valid && bus.ready);
            if (occ > max_occ) max_occ = occ;
            prev_stall = bus.valid && !bus.ready;
            prev_data = bus.data;
            if (post > 0) post--;
            cyc++;
        end
        bus.start = 1'b0;
        if (post != 0) timed_out = 1;
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.base_addr = '0; bus.len = '0; bus.ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl busy=%b done=%b want 0 0", bus.busy, bus.done);
        end
        vectors++;
        if (bus.ram_rd_en !== 1'b0 || bus.ram_addr !== '0) begin
            miscompares++;
            $display("FAIL reset_ram rd_en=%b addr=%0d want 0 0", bus.ram_rd_en, bus.ram_addr);
        end
        vectors++;
        if (bus.valid !== 1'b0 || bus.last !== 1'b0 || bus.data !== '0) begin
            miscompares++;
            $display("FAIL reset_stream valid=%b last=%b data=%h want 0 0 0", bus.valid, bus.last, bus.data);
        end
        vectors++;
        if (bus.perf_stall !== 32'd0 || bus.dbg_state !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_misc perf=%0d state=%0d want 0 0", bus.perf_stall, bus.dbg_state);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [DATA_WIDTH-1:0] exp_q[$];
        for (int i = 0; i < RAM_DEPTH; i++) mem[i] = DATA_WIDTH'(i);
        for (int k = 0; k < 8; k++) exp_q.push_back(DATA_WIDTH'((10 + k) % RAM_DEPTH));
        run_burst(10, 8, 0, 0, -1);
        vectors++;
        if (timed_out || got_data.size() != 8) begin
            miscompares++;
            $display("FAIL basic_count got %0d words timeout=%0d want 8", got_data.size(), timed_out);
        end
        for (int k = 0; k < exp_q.size(); k++) begin
            vectors++;
            if (k >= got_data.size() || got_data[k] !== exp_q[k] || got_last[k] !== (k == 7)) begin
                miscompares++;
                $display("FAIL basic_word%0d got %h/last%b want %h/last%b", k,
                         (k < got_data.size()) ? got_data[k] : '0,
                         (k < got_last.size()) ? got_last[k] : 1'b0, exp_q[k], k == 7);
            end
        end
        vectors++;
        if (first_valid_cyc != 3) begin
            miscompares++;
            $display("FAIL basic_latency got %0d want 3", first_valid_cyc);
        end
        vectors++;
        if (last_acc_cyc - first_valid_cyc != 7) begin
            miscompares++;
            $display("FAIL basic_throughput span %0d want 7", last_acc_cyc - first_valid_cyc);
        end
        vectors++;
        if (done_cnt != 1 || done_cyc != last_acc_cyc + 1) begin
            miscompares++;
            $display("FAIL basic_done count %0d at %0d want 1 at %0d", done_cnt, done_cyc, last_acc_cyc + 1);
        end
    endtask

    task automatic test_wrap();
        logic [ADDR_WIDTH-1:0] exp_a[$];
        for (int k = 0; k < 4; k++) exp_a.push_back(ADDR_WIDTH'((RAM_DEPTH - 2 + k) % RAM_DEPTH));
        run_burst(RAM_DEPTH - 2, 4, 0, 0, -1);
        vectors++;
        if (timed_out || got_addr.size() != 4 || got_data.size() != 4) begin
            miscompares++;
            $display("FAIL wrap_count reads %0d words %0d want 4 4", got_addr.size(), got_data.size());
        end
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (k >= got_addr.size() || k >= got_data.size() ||
                got_addr[k] !== exp_a[k] || got_data[k] !== mem[exp_a[k]]) begin
                miscompares++;
                $display("FAIL wrap_step%0d addr %0d data %h want %0d %h", k,
                         (k < got_addr.size()) ? got_addr[k] : '0,
                         (k < got_data.size()) ? got_data[k] : '0, exp_a[k], mem[exp_a[k]]);
            end
        end
    endtask

    task automatic test_backpressure();
        int base, len, bad;
        for (int i = 0; i < RAM_DEPTH; i++) mem[i] = $urandom;
        for (int t = 0; t < 4; t++) begin
            logic [DATA_WIDTH-1:0] exp_q[$];
            base = $urandom_range(0, RAM_DEPTH - 1);
            len = (t == 0) ? 16 : $urandom_range(1, 40);
            for (int k = 0; k < len; k++) exp_q.push_back(mem[(base + k) % RAM_DEPTH]);
            run_burst(base, len, 1, 0, -1);
            bad = 0;
            for (int k = 0; k < len; k++)
                if (k >= got_data.size() || got_data[k] !== exp_q[k]) bad++;
            vectors++;
            if (timed_out || bad != 0 || got_data.size() != len) begin
                miscompares++;
                $display("FAIL bp_data%0d words %0d bad %0d want %0d words 0 bad", t, got_data.size(), bad, len);
            end
            vectors++;
            if (stall_viol != 0 || max_occ > FIFO_DEPTH) begin
                miscompares++;
                $display("FAIL bp_stall%0d unstable %0d max_occ %0d want 0 <=%0d", t, stall_viol, max_occ, FIFO_DEPTH);
            end
            vectors++;
            if (done_cnt != 1 || got_addr.size() != len) begin
                miscompares++;
                $display("FAIL bp_done%0d dones %0d reads %0d want 1 %0d", t, done_cnt, got_addr.size(), len);
            end
        end
    endtask

    task automatic test_hold();
        int base, bad, exp_perf;
        logic [DATA_WIDTH-1:0] exp_q[$];
        base = $urandom_range(0, RAM_DEPTH - 1);
        for (int k = 0; k < 12; k++) exp_q.push_back(mem[(base + k) % RAM_DEPTH]);
        run_burst(base, 12, 2, 20, -1);
        vectors++;
        if (reads_in_hold != FIFO_DEPTH) begin
            miscompares++;
            $display("FAIL hold_reads got %0d want %0d", reads_in_hold, FIFO_DEPTH);
        end
        bad = 0;
        for (int k = 0; k < 12; k++)
            if (k >= got_data.size() || got_data[k] !== exp_q[k]) bad++;
        vectors++;
        if (timed_out || bad != 0 || got_data.size() != 12 || stall_viol != 0) begin
            miscompares++;
            $display("FAIL hold_data words %0d bad %0d unstable %0d want 12 0 0", got_data.size(), bad, stall_viol);
        end
`ifdef RAM_BURST_READER_PERF_EN
        exp_perf = 20 - 2;  // valid first appears in cycle 3 of the 20 held cycles
`else
        exp_perf = 0;
`endif
        vectors++;
        if (bus.perf_stall !== 32'(exp_perf)) begin
            miscompares++;
            $display("FAIL hold_perf got %0d want %0d", bus.perf_stall, exp_perf);
        end
    endtask

    task automatic test_zero_len_and_busy_start();
        int dones, reads, busy_seen, dcyc, bad;
        bus.ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b1; bus.len = '0; bus.base_addr = ADDR_WIDTH'(7);
        dones = 0; reads = 0; busy_seen = 0; dcyc = -1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.done) begin dones++; dcyc = c; end
            if (bus.ram_rd_en) reads++;
            if (bus.busy) busy_seen++;
        end
        vectors++;
        if (dones != 1 || dcyc != 1) begin
            miscompares++;
            $display("FAIL zero_done count %0d at %0d want 1 at 1", dones, dcyc);
        end
        vectors++;
        if (reads != 0 || busy_seen != 0) begin
            miscompares++;
            $display("FAIL zero_idle reads %0d busy %0d want 0 0", reads, busy_seen);
        end
        run_burst(40, 8, 0, 0, 5);
        bad = 0;
        for (int k = 0; k < 8; k++)
            if (k >= got_data.size() || got_data[k] !== mem[40 + k]) bad++;
        vectors++;
        if (timed_out || bad != 0 || got_data.size() != 8 || got_addr.size() != 8 || done_cnt != 1) begin
            miscompares++;
            $display("FAIL busy_start words %0d reads %0d bad %0d dones %0d want 8 8 0 1",
                     got_data.size(), got_addr.size(), bad, done_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int cyc, acc, dones, busy_seen, bad;
        bit fired;
        bus.ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b1; bus.base_addr = ADDR_WIDTH'(20); bus.len = 10'd8;
        acc = 0; fired = 0; cyc = 0;
        while (!fired && cyc < 50) begin
            @(negedge clk);
            bus.start = 1'b0;
            cyc++;
            if (bus.valid && acc == 2) begin
                rst_n = 1'b0;
                fired = 1;
                #1;
                vectors++;
                if (bus.busy !== 1'b0 || bus.valid !== 1'b0 || bus.last !== 1'b0 || bus.data !== '0 ||
                    bus.ram_rd_en !== 1'b0 || bus.ram_addr !== '0 || bus.done !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rstmid_outputs busy%b valid%b last%b data%h rden%b addr%0d done%b want all 0",
                             bus.busy, bus.valid, bus.last, bus.data, bus.ram_rd_en, bus.ram_addr, bus.done);
                end
            end else if (bus.valid) begin
                acc++;
            end
        end
        vectors++;
        if (!fired) begin
            miscompares++;
            $display("FAIL rstmid_timeout accepted %0d want third word within 50 cycles", acc);
        end
        dones = 0; busy_seen = 0;
        repeat (3) @(negedge clk) if (bus.done) dones++;
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (bus.done) dones++;
            if (bus.busy || bus.valid || bus.ram_rd_en) busy_seen++;
        end
        vectors++;
        if (dones != 0 || busy_seen != 0) begin
            miscompares++;
            $display("FAIL rstmid_quiet dones %0d activity %0d want 0 0", dones, busy_seen);
        end
        run_burst(300, 8, 1, 0, -1);
        bad = 0;
        for (int k = 0; k < 8; k++)
            if (k >= got_data.size() || got_data[k] !== mem[300 + k]) bad++;
        vectors++;
        if (timed_out || bad != 0 || got_data.size() != 8 || done_cnt != 1) begin
            miscompares++;
            $display("FAIL rstmid_after words %0d bad %0d dones %0d want 8 0 1", got_data.size(), bad, done_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int base, len, bad;
        for (int t = 0; t < 3; t++) begin
            base = $urandom_range(0, RAM_DEPTH - 1);
            len = $urandom_range(1, 20);
            run_burst(base, len, 0, 0, -1);
            bad = 0;
            for (int k = 0; k < len; k++)
                if (k >= got_data.size() || got_data[k] !== mem[(base + k) % RAM_DEPTH] ||
                    got_last[k] !== (k == len - 1)) bad++;
            vectors++;
            if (timed_out || bad != 0 || got_data.size() != len || last_acc_cyc - first_valid_cyc != len - 1) begin
                miscompares++;
                $display("FAIL b2b%0d words %0d bad %0d span %0d want %0d 0 %0d", t, got_data.size(), bad,
                         last_acc_cyc - first_valid_cyc, len, len - 1);
            end
        end
    endtask

    task automatic test_long();
        int base, bad, hits;
        int lens[2];
        lens[0] = RAM_DEPTH;
        lens[1] = RAM_DEPTH + 8;
        for (int t = 0; t < 2; t++) begin
            int seen[RAM_DEPTH];
            base = $urandom_range(0, RAM_DEPTH - 1);
            run_burst(base, lens[t], t, 0, -1);
            bad = 0;
            for (int i = 0; i < RAM_DEPTH; i++) seen[i] = 0;
            for (int k = 0; k < got_addr.size(); k++) seen[got_addr[k]]++;
            hits = 0;
            for (int i = 0; i < RAM_DEPTH; i++) if (seen[i] >= 1) hits++;
            for (int k = 0; k < lens[t]; k++)
                if (k >= got_data.size() || got_data[k] !== mem[(base + k) % RAM_DEPTH]) bad++;
            vectors++;
            if (timed_out || bad != 0 || got_data.size() != lens[t] || got_addr.size() != lens[t] ||
                hits != RAM_DEPTH) begin
                miscompares++;
                $display("FAIL long%0d words %0d reads %0d bad %0d distinct %0d want %0d %0d 0 %0d", t,
                         got_data.size(), got_addr.size(), bad, hits, lens[t], lens[t], RAM_DEPTH);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_hold();
        test_zero_len_and_busy_start();
        test_reset_mid();
        test_back_to_back();
        test_long();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
